// File: rtl/jumptarg_pipe.sv
// Registered JAL/JALR/BRANCH target generator sitting on the ID/EX boundary.
// Define JUMPTARG_RAS_EN to compile in the return-address stack predictor.
module jumptarg_pipe #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            stall,
    input  logic            flush,
    input  logic [31:0]     instrn,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1,
    output logic            out_valid,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] link,
    output logic [1:0]      kind,
    output logic            misaligned,
    output logic            ras_hit,
    output logic [XLEN-1:0] ras_target
);
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] KIND_NONE   = 2'd0;
    localparam logic [1:0] KIND_JAL    = 2'd1;
    localparam logic [1:0] KIND_JALR   = 2'd2;
    localparam logic [1:0] KIND_BRANCH = 2'd3;

    logic            accept;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] link_d;
    logic [XLEN-1:0] target_d;
    logic [1:0]      kind_d;

    assign accept   = in_valid & ~stall & ~flush;
    assign imm_j    = {{(XLEN-21){instrn[31]}}, instrn[31], instrn[19:12], instrn[20],
                       instrn[30:21], 1'b0};
    assign imm_i    = {{(XLEN-12){instrn[31]}}, instrn[31:20]};
    assign imm_b    = {{(XLEN-13){instrn[31]}}, instrn[31], instrn[7], instrn[30:25],
                       instrn[11:8], 1'b0};
    assign jalr_sum = rs1 + imm_i;
    assign link_d   = pc + XLEN'(4);

    always_comb begin
        kind_d   = KIND_NONE;
        target_d = '0;
        case (instrn[6:0])
            OP_JAL: begin
                kind_d   = KIND_JAL;
                target_d = pc + imm_j;
            end
            OP_JALR: begin
                kind_d   = KIND_JALR;
                target_d = {jalr_sum[XLEN-1:1], 1'b0};
            end
            OP_BRANCH: begin
                kind_d   = KIND_BRANCH;
                target_d = pc + imm_b;
            end
            default: ;
        endcase
    end

    // flush wins over stall; an idle cycle only drops out_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            target     <= '0;
            link       <= '0;
            kind       <= KIND_NONE;
            misaligned <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            kind       <= KIND_NONE;
            misaligned <= 1'b0;
        end else if (accept) begin
            out_valid  <= (kind_d != KIND_NONE);
            target     <= target_d;
            link       <= link_d;
            kind       <= kind_d;
            misaligned <= target_d[1];
        end else if (!stall) begin
            out_valid  <= 1'b0;
        end
    end

`ifdef JUMPTARG_RAS_EN
    localparam int             PTR_W     = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(RAS_DEPTH);

    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W-1:0] ptr_after_pop;
    logic [PTR_W-1:0] ptr_nxt;
    logic [PTR_W:0]   ras_cnt;
    logic [PTR_W:0]   cnt_after_pop;
    logic [PTR_W:0]   cnt_nxt;
    logic [4:0]       rd_idx;
    logic [4:0]       rs_idx;
    logic             rd_link;
    logic             rs_link;
    logic             push;
    logic             pop;
    logic             pop_hit;

    assign rd_idx  = instrn[11:7];
    assign rs_idx  = instrn[19:15];
    assign rd_link = (rd_idx == 5'd1) || (rd_idx == 5'd5);
    assign rs_link = (rs_idx == 5'd1) || (rs_idx == 5'd5);
    assign push    = accept && ((kind_d == KIND_JAL) || (kind_d == KIND_JALR)) && rd_link;
    assign pop     = accept && (kind_d == KIND_JALR) && rs_link
                     && (!rd_link || (rd_idx != rs_idx));
    assign pop_hit = pop && (ras_cnt != '0);

    // ras_ptr is the next free slot; a pop+push rewrites the current top in place
    assign top_idx       = ras_ptr - PTR_W'(1);
    assign ptr_after_pop = pop_hit ? top_idx : ras_ptr;
    assign cnt_after_pop = pop_hit ? ras_cnt - (PTR_W+1)'(1) : ras_cnt;
    assign ptr_nxt       = push ? ptr_after_pop + PTR_W'(1) : ptr_after_pop;
    assign cnt_nxt       = (push && (cnt_after_pop != DEPTH_CNT))
                           ? cnt_after_pop + (PTR_W+1)'(1) : cnt_after_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_ptr    <= '0;
            ras_cnt    <= '0;
            ras_hit    <= 1'b0;
            ras_target <= '0;
        end else begin
            ras_ptr <= ptr_nxt;
            ras_cnt <= cnt_nxt;
            if (flush) begin
                ras_hit <= 1'b0;
            end else if (accept) begin
                ras_hit    <= pop_hit;
                ras_target <= pop_hit ? ras_mem[top_idx] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[ptr_after_pop] <= link_d;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = (RAS_DEPTH > 1);
    assign ras_hit    = 1'b0;
    assign ras_target = '0;
`endif

endmodule

// File: tb/tb_jumptarg_pipe.sv
// Bench for jumptarg_pipe: directed vector table, stall/flush/reset and RAS
// sequences, then random traffic against a queue-based reference model.
module tb_jumptarg_pipe;
    localparam int RAS_DEPTH = 4;
`ifdef JUMPTARG_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instrn = '0;
    logic [31:0] pc = '0;
    logic [31:0] rs1 = '0;
    logic        out_valid;
    logic [31:0] target;
    logic [31:0] link;
    logic [1:0]  kind;
    logic        misaligned;
    logic        ras_hit;
    logic [31:0] ras_target;

    jumptarg_pipe #(.XLEN(32), .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .instrn(instrn), .pc(pc), .rs1(rs1), .out_valid(out_valid), .target(target),
        .link(link), .kind(kind), .misaligned(misaligned), .ras_hit(ras_hit),
        .ras_target(ras_target)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state; k_* mark fields whose value the rules define
    logic        m_ov, m_mis, m_hit;
    logic [1:0]  m_kind;
    logic [31:0] m_tgt, m_lnk, m_rt;
    bit          k_tgt, k_mis, k_rt;
    logic [31:0] ras_q[$];

    typedef struct {
        logic [31:0] instrn;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [1:0]  kind;
        logic [31:0] tgt;
        logic [31:0] lnk;
        logic        mis;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_decode(input logic [31:0] i, input logic [31:0] p,
                                       input logic [31:0] r, output logic [1:0] k,
                                       output logic [31:0] t);
        logic [31:0] imm;
        k = 2'd0;
        t = '0;
        case (i[6:0])
            7'b1101111: begin
                imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
                k   = 2'd1;
                t   = p + imm;
            end
            7'b1100111: begin
                imm = 32'($signed(i[31:20]));
                k   = 2'd2;
                t   = (r + imm) & 32'hFFFF_FFFE;
            end
            7'b1100011: begin
                imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
                k   = 2'd3;
                t   = p + imm;
            end
            default: ;
        endcase
    endfunction

    task automatic model_reset();
        m_ov = 0; m_mis = 0; m_hit = 0; m_kind = 0;
        m_tgt = 0; m_lnk = 0; m_rt = 0;
        k_tgt = 1; k_mis = 1; k_rt = 1;
        ras_q.delete();
    endtask

    task automatic model_step();
        logic [1:0]  k;
        logic [31:0] t;
        logic [4:0]  rd, rsn;
        bit          rdl, rsl, do_push, do_pop;
        if (flush) begin
            m_ov = 0; m_kind = 0; m_mis = 0; k_mis = 1; m_hit = 0;
        end else if (stall) begin
        end else if (in_valid) begin
            ref_decode(instrn, pc, rs1, k, t);
            m_kind = k;
            m_ov   = (k != 0);
            m_lnk  = pc + 32'd4;
            if (k != 0) begin
                m_tgt = t; k_tgt = 1; m_mis = t[1]; k_mis = 1;
            end else begin
                k_tgt = 0; k_mis = 0;
            end
            m_hit = 0;
            if (RAS_ON) begin
                rd  = instrn[11:7];
                rsn = instrn[19:15];
                rdl = (rd == 1) || (rd == 5);
                rsl = (rsn == 1) || (rsn == 5);
                do_push = ((k == 1) || (k == 2)) && rdl;
                do_pop  = (k == 2) && rsl && (!rdl || (rd != rsn));
                k_rt = 0;
                if (do_pop) begin
                    k_rt = 1;
                    if (ras_q.size() > 0) begin
                        m_rt  = ras_q.pop_back();
                        m_hit = 1;
                    end else begin
                        m_rt = 0;
                    end
                end
                if (do_push) begin
                    ras_q.push_back(pc + 32'd4);
                    if (ras_q.size() > RAS_DEPTH) ras_q.delete(0);
                end
            end else begin
                m_rt = 0; k_rt = 1;
            end
        end else begin
            m_ov = 0;
        end
    endtask

    task automatic compare_all();
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("kind", 32'(kind), 32'(m_kind));
        chk("link", link, m_lnk);
        chk("ras_hit", 32'(ras_hit), 32'(m_hit));
        if (k_tgt) chk("target", target, m_tgt);
        if (k_mis) chk("misaligned", 32'(misaligned), 32'(m_mis));
        if (k_rt) chk("ras_target", ras_target, m_rt);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_in(input logic v, input logic [31:0] i, input logic [31:0] p,
                          input logic [31:0] r);
        in_valid = v; instrn = i; pc = p; rs1 = r;
    endtask

    task automatic do_reset();
        rst = 1; in_valid = 0; stall = 0; flush = 0;
        @(posedge clk);
        #1;
        model_reset();
        compare_all();
        rst = 0;
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd5;
            default: return 5'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        i = $urandom;
        case ($urandom_range(0, 3))
            0: i[6:0] = 7'b1101111;
            1: i[6:0] = 7'b1100111;
            2: i[6:0] = 7'b1100011;
            default: if (i[6:0] inside {7'b1101111, 7'b1100111, 7'b1100011}) i[6:0] = 7'b0010011;
        endcase
        if (i[6:0] != 7'b1100011) begin
            i[11:7]  = pick_reg();
            i[19:15] = pick_reg();
        end
        return i;
    endfunction

    logic [31:0] ret_exp[4];

    initial begin
        vecs[0] = '{32'h008000EF, 32'h100, 32'h0,   2'd1, 32'h108,       32'h104, 1'b0};
        vecs[1] = '{32'h00008067, 32'h300, 32'h205, 2'd2, 32'h204,       32'h304, 1'b0};
        vecs[2] = '{32'h00008067, 32'h300, 32'h102, 2'd2, 32'h102,       32'h304, 1'b1};
        vecs[3] = '{32'hFE000EE3, 32'h200, 32'h0,   2'd3, 32'h1FC,       32'h204, 1'b0};
        vecs[4] = '{32'hFE000EE3, 32'h2,   32'h0,   2'd3, 32'hFFFFFFFE,  32'h6,   1'b1};
        vecs[5] = '{32'h00000013, 32'h40,  32'h0,   2'd0, 32'h0,         32'h44,  1'b0};

        #2;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_target", target, 32'd0);
        do_reset();

        for (int v = 0; v < 6; v++) begin
            set_in(1'b1, vecs[v].instrn, vecs[v].pc, vecs[v].rs1);
            cycle();
            chk($sformatf("tbl%0d_kind", v), 32'(kind), 32'(vecs[v].kind));
            chk($sformatf("tbl%0d_out_valid", v), 32'(out_valid), 32'(vecs[v].kind != 0));
            chk($sformatf("tbl%0d_link", v), link, vecs[v].lnk);
            if (vecs[v].kind != 0) begin
                chk($sformatf("tbl%0d_target", v), target, vecs[v].tgt);
                chk($sformatf("tbl%0d_misaligned", v), 32'(misaligned), 32'(vecs[v].mis));
            end
        end

        set_in(1'b0, 32'h0, 32'h0, 32'h0);
        cycle();
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_link_hold", link, 32'h44);

        // stall freeze, flush over stall, then async reset while stalled
        do_reset();
        set_in(1'b1, 32'h008000EF, 32'h100, 32'h0);
        cycle();
        stall = 1;
        for (int s = 0; s < 3; s++) begin
            set_in(1'b1, 32'hFE000EE3, 32'h200 + 32'(s * 16), $urandom);
            cycle();
            chk("stall_target", target, 32'h108);
            chk("stall_kind", 32'(kind), 32'd1);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
        end
        flush = 1;
        cycle();
        chk("flush_stall_out_valid", 32'(out_valid), 32'd0);
        chk("flush_stall_kind", 32'(kind), 32'd0);
        flush = 0;
        set_in(1'b1, 32'h008000EF, 32'h100, 32'h0);
        cycle();
        #2;
        rst = 1;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_target", target, 32'd0);
        chk("async_rst_link", link, 32'd0);
        chk("async_rst_kind", 32'(kind), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 0; stall = 0;

        // jalr return with an empty stack
        set_in(1'b1, 32'h00008067, 32'h10, 32'h40);
        cycle();
        chk("empty_ras_hit", 32'(ras_hit), 32'd0);
        chk("empty_ras_target", ras_target, 32'd0);

`ifdef JUMPTARG_RAS_EN
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            set_in(1'b1, 32'h000000EF, 32'(c * 256), 32'h0);
            cycle();
        end
        ret_exp = '{32'h504, 32'h404, 32'h304, 32'h204};
        for (int r = 0; r < 5; r++) begin
            set_in(1'b1, 32'h00008067, 32'h800, 32'h504);
            cycle();
            if (r < 4) begin
                chk($sformatf("ret%0d_ras_hit", r), 32'(ras_hit), 32'd1);
                chk($sformatf("ret%0d_ras_target", r), ras_target, ret_exp[r]);
            end else begin
                chk("ret4_ras_hit", 32'(ras_hit), 32'd0);
                chk("ret4_ras_target", ras_target, 32'd0);
            end
        end
`endif

        do_reset();
        for (int n = 0; n < 3000; n++) begin
            in_valid = ($urandom_range(0, 4) != 0);
            stall    = ($urandom_range(0, 6) == 0);
            flush    = ($urandom_range(0, 10) == 0);
            instrn   = rand_instr();
            pc       = $urandom;
            rs1      = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/jumptarg_pipe.md
# jumptarg_pipe

Parametrised, registered jump/branch target generator for the ID/EX boundary. It decodes JAL, JALR and conditional-branch instructions and computes the target address and link value (PC+4). It also flags misaligned targets and presents the results one cycle later through a valid/stall/flush pipeline register. An optional return-address stack (RAS) provides a predicted return target for JALR returns.

## Interface
- `XLEN`, default 32: address/data width, ≥ 32.
- `RAS_DEPTH`, default 4: RAS entries, power of two, ≥ 2. Used only with `JUMPTARG_RAS_EN`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  instruction on `instrn`/`pc`/`rs1` is valid this cycle.
- `stall`  in  1  hold the output register.
- `flush`  in  1  kill the output register contents.
- `instrn`  in  32  RV32 instruction word.
- `pc`  in  XLEN  PC of `instrn`.
- `rs1`  in  XLEN  forwarded rs1 value.
- `out_valid`  out  1  output register holds a decoded control-transfer instruction.
- `target`  out  XLEN  computed target.
- `link`  out  XLEN  PC+4.
- `kind`  out  2  0 none, 1 JAL, 2 JALR, 3 BRANCH.
- `misaligned`  out  1  `target[1]` is set.
- `ras_hit`  out  1  RAS prediction valid (0 when the macro is off).
- `ras_target`  out  XLEN  RAS predicted return (0 when the macro is off).

## Operation
- Opcode `instrn[6:0]` selects the operation:
  - `1101111` JAL: imm = {instrn[31], [19:12], [20], [30:21], 0}; target = pc+imm.
  - `1100111` JALR: imm = sext(instrn[31:20]); target = (rs1+imm) & ~1.
  - `1100011` BRANCH: imm = {instrn[31], [7], [30:25], [11:8], 0}; target = pc+imm.
  - Any other opcode: kind=0.
- All immediates are sign-extended to XLEN. Additions are modulo 2^XLEN, with no overflow flag.
- `link` = pc+4 for every kind. Branch taken/not-taken is resolved downstream, not here.
- Accept condition: `in_valid & ~stall & ~flush`. On accept, the register loads all fields, and `out_valid` = (kind≠0).
- `in_valid=0` with no stall or flush: `out_valid` clears to 0, and the other fields hold.
- Priority is `rst` > `flush` > `stall` > accept.
  - `flush` clears `out_valid`, `kind`, `misaligned` and `ras_hit`, even when `stall` is asserted.
  - `stall` holds every output.

## Timing
- Latency is 1 cycle from accept to output. No combinational path runs from inputs to outputs.
- Reset value of every output is 0. RAS pointer and count reset to 0.
- Reset asserted mid-operation clears all state immediately (asynchronously). The first accept is possible on the first rising edge after deassertion.
- Throughput is one instruction per cycle when `stall`=0.

## Configuration
- `JUMPTARG_RAS_EN` defined: the RAS is compiled in. Link registers are x1 and x5.
  - push when an accepted JAL/JALR has rd ∈ {x1, x5}; the pushed value is `link`.
  - pop when an accepted JALR has rs1 ∈ {x1, x5} and rd ∉ {x1, x5}.
  - JALR with rd and rs1 both link registers: if rd==rs1, push only; otherwise pop then push, which replaces the top entry and leaves count unchanged.
  - On pop, `ras_target` = top entry and `ras_hit`=1, both registered alongside `target`.
  - Empty pop: `ras_hit`=0, `ras_target`=0, count stays 0.
  - Full push: the circular pointer wraps and overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Stalled, flushed or invalid cycles never modify the RAS.
- `JUMPTARG_RAS_EN` undefined: no RAS storage. `ras_hit` and `ras_target` are tied to 0.

## Test plan
- JAL: pc=0x100, instrn=0x008000EF, accept → next cycle out_valid=1, kind=1, target=0x108, link=0x104, misaligned=0.
- JALR: instrn=0x00008067, rs1=0x205 → target=0x204 (bit 0 cleared), kind=2. Same instruction with rs1=0x102 → target=0x102, misaligned=1.
- BRANCH: pc=0x200, instrn=0xFE000EE3 → target=0x1FC, kind=3. With pc=0x2, imm −4 → target wraps to 0xFFFFFFFE.
- Stall/flush: accept JAL, then assert stall 3 cycles while inputs change → outputs frozen. Assert flush and stall together → out_valid=0 next cycle. Assert rst mid-stall → all outputs 0 without a clock edge.
- RAS (macro on, depth 4):
  - 5 `jal x1` calls from pc 0x100, 0x200, 0x300, 0x400, 0x500.
  - 5 `jalr x0,0(x1)` returns → ras_target 0x504, 0x404, 0x304, 0x204 with ras_hit=1, then fifth return gives ras_hit=0.
- RAS off, or empty: `jalr x0,0(x1)` after reset → ras_hit=0, ras_target=0.
